// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences a WIDTH-bit universal shift register to send a parallel word
// out serially. The sequence is IDLE -> LOAD -> SHIFT (cnt cycles) -> DONE.
// Optional macro SHIFT_SEQUENCER_ROTATE_EN adds a 'rotate' input. When it is set, the
// departing bit is fed back into the vacated end, so the word survives a full WIDTH-shift pass.
module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3,
  parameter logic        FILL  = 1'b0
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] A_par,
  output logic             s1,
  output logic             s0,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] OneCnt   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_lat;
  logic             rot_q;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic rot_d;
`else
  assign rot_q = 1'b0;
`endif

  // Only the end bits of A_par are used. This sink keeps the middle bits lint-quiet.
  logic unused_par;
  assign unused_par = ^A_par;

  // A count of 0, or a count above WIDTH, both mean a full-width transfer.
  assign cnt_lat = (count == '0 || count > WidthCnt) ? WidthCnt : count;

  // Next-state logic: start is sampled only in IDLE, so it is never queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    rot_d   = rot_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = cnt_lat;
          dir_d   = dir;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
          rot_d   = rotate;
`endif
        end
      end
      StLoad: state_d = StShift;
      StShift: begin
        cnt_d = cnt_q - OneCnt;
        if (cnt_q == OneCnt) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers. An asynchronous clear abandons any transfer in flight.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Moore decode of the register controls. Serial and fill bits also tap A_par.
  always_comb begin
    s1        = 1'b0;
    s0        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    MSB_in    = FILL;
    LSB_in    = FILL;
    unique case (state_q)
      StLoad: begin
        s1   = 1'b1;
        s0   = 1'b1;
        busy = 1'b1;
      end
      StShift: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        if (dir_q) begin
          s1      = 1'b1;
          ser_out = A_par[WIDTH-1];
        end else begin
          s0      = 1'b1;
          ser_out = A_par[0];
        end
        if (rot_q) begin
          MSB_in = A_par[0];
          LSB_in = A_par[WIDTH-1];
        end
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that sequences a WIDTH-bit universal shift register (parallel load, then shift left/right) to perform serial transmission of a parallel word.
- Drives the register's select lines s1/s0 and serial fill inputs MSB_in/LSB_in.
- Taps the register's parallel output A_par to present the departing bit as a serial stream.
- Offers a start/busy/done handshake to the upstream requester. Sits between requester logic and one register instance.

Parameters:
- WIDTH, 4: register width in bits.
- CNT_W, 3: width of count input and internal shift counter; must satisfy 2^CNT_W > WIDTH.
- FILL, 1'b0: constant bit shifted into the vacated end when rotation is not in use.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- Clear_b  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dir  input  1  0 = shift right (LSB first), 1 = shift left (MSB first); latched on accepted start.
- count  input  CNT_W  number of shifts, 1..WIDTH; 0 means WIDTH; latched on accepted start.
- A_par  input  WIDTH  parallel output of the controlled register.
- s1  output  1  register select high bit.
- s0  output  1  register select low bit.
- MSB_in  output  1  serial fill for right shift.
- LSB_in  output  1  serial fill for left shift.
- ser_out  output  1  bit leaving the register this cycle.
- ser_valid  output  1  ser_out is meaningful.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE; state, dir_q and cnt are registers; all outputs decode from them (Moore), except ser_out and fill bits, which also use A_par.
- Reset (Clear_b=0, asynchronous):
  - State goes to IDLE; cnt=0; dir_q=0.
  - Outputs: s1s0=00, busy=0, done=0, ser_valid=0, ser_out=0.
  - Reset mid-operation abandons the transfer with no done pulse.
- IDLE:
  - s1s0=00 (hold).
  - start=1 at an edge: latch dir and count (count 0 becomes WIDTH), go to LOAD.
  - start=0: stay in IDLE.
- LOAD:
  - Lasts exactly 1 cycle; s1s0=11, so the register loads its parallel input at the next edge.
  - busy=1; go to SHIFT.
- SHIFT:
  - Lasts exactly cnt cycles; busy=1, ser_valid=1.
  - dir_q=0: s1s0=01, ser_out=A_par[0].
  - dir_q=1: s1s0=10, ser_out=A_par[WIDTH-1].
  - ser_out is the bit present before the edge that shifts it out.
  - cnt decrements each edge; the edge where cnt==1 moves to DONE.
- DONE:
  - Lasts 1 cycle; s1s0=00, done=1, busy=0, ser_valid=0; go to IDLE.
- Latency: accepted start → done high after 2+cnt edges; total occupancy is cnt+2 cycles.
- start outside IDLE (including in DONE) is ignored; it is not queued.
- Back-to-back transfers: start may be held high; the next transfer begins at the first edge in IDLE. Minimum gap is one IDLE cycle.
- Fill outputs: MSB_in = LSB_in = FILL in all states (unless the optional feature is active).
- count > WIDTH: clamped to WIDTH at latch.

Optional Feature:
- Macro: SHIFT_SEQUENCER_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit), latched with dir on accepted start.
  - When latched rotate=1 and in SHIFT, MSB_in = A_par[0] and LSB_in = A_par[WIDTH-1], so the word rotates and is preserved after WIDTH shifts.
  - With latched rotate=0, fill = FILL.
- Undefined:
  - rotate port absent; fill is always FILL.

Test Plan:
- Bench setup: I_par=4'b1010, dir=0, count=4, start pulsed 1 cycle → ser_valid high for 4 cycles, ser_out=0,1,0,1. The done pulse follows 6 edges after start. Final A_par=0000 (FILL=0).
- I_par=1010, dir=1, count=2 → ser_out=1,0; s1s0=10 for 2 cycles; final A_par=1000; done after 4 edges.
- count=0, dir=0, I_par=0110 → exactly 4 shift cycles, ser_out=0,1,1,0.
- start re-asserted during SHIFT → ignored, one done pulse only. start held high continuously → transfers repeat with a single IDLE cycle between.
- Clear_b low at the second SHIFT cycle → immediately s1s0=00, busy=0, ser_valid=0. No done pulse; after release, the block is in IDLE and accepts a new start.
- With SHIFT_SEQUENCER_ROTATE_EN: rotate=1, dir=0, count=4, I_par=1010 → ser_out=0,1,0,1 and final A_par=1010. With rotate=0 → final A_par=0000.
